// File: rtl/proc_pkg.sv
// proc_pkg: shared widths, link stack depth and fetch FSM state type
package proc_pkg;
    localparam int ADDR_W     = 16;
    localparam int INS_W      = 21;
    localparam int LINK_DEPTH = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} fetch_state_e;
endpackage

// File: rtl/link_stack.sv
// link_stack: LIFO of return addresses; exists only when LINK_STACK_EN is defined
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push        store din as the new top (oldest entry dropped when full)
//   pop         discard the top; popping an empty stack sets err
//   push & pop  replace the top with din
//   din         address to store
//   top         current top entry, 0 when empty
//   err         sticky underflow flag, cleared only by reset
`ifdef LINK_STACK_EN
module link_stack
    import proc_pkg::*;
#(
    parameter int W     = ADDR_W,
    parameter int DEPTH = LINK_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         err
);
    localparam int CW = $clog2(DEPTH + 1);

    // stk[0] is the top; entries at or beyond cnt are stale and never shown
    logic [W-1:0]  stk [DEPTH];
    logic [CW-1:0] cnt;
    logic          empty;

    assign empty = cnt == '0;
    assign top   = empty ? '0 : stk[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
        end else if (push && pop) begin
            stk[0] <= din;
            if (empty) begin
                cnt <= CW'(1);
                err <= 1'b1;
            end
        end else if (push) begin
            stk[0] <= din;
            for (int i = 1; i < DEPTH; i++) stk[i] <= stk[i-1];
            if (cnt != CW'(DEPTH)) cnt <= cnt + CW'(1);
        end else if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) stk[i] <= stk[i+1];
            stk[DEPTH-1] <= '0;
            if (empty) err <= 1'b1;
            else cnt <= cnt - CW'(1);
        end
    end
endmodule
`endif

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC/link owner, synchronous imem reader, valid/ready instruction source
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_addr, imem_en         memory address (= PC) and read enable
//   imem_data                  read data, one cycle after imem_en
//   ins, ins_addr, ins_valid   fetched instruction and its address
//   ins_ready                  decoder accepts the held instruction
//   load_pc, new_pc            redirect target, applied on acceptance
//   load_linkreg, new_linkreg  link update (call), applied on acceptance
//   ret                        next PC = link value, applied on acceptance
//   linkreg, stack_err         link value / top of stack, sticky underflow
// Build option: LINK_STACK_EN turns the link register into a 4-entry LIFO.
module instruction_fetch
    import proc_pkg::*;
#(
    parameter int                ADDR_W   = proc_pkg::ADDR_W,
    parameter int                INS_W    = proc_pkg::INS_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_en,
    input  logic [INS_W-1:0]  imem_data,
    output logic [INS_W-1:0]  ins,
    output logic [ADDR_W-1:0] ins_addr,
    output logic              ins_valid,
    input  logic              ins_ready,
    input  logic              load_pc,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              load_linkreg,
    input  logic [ADDR_W-1:0] new_linkreg,
    input  logic              ret,
    output logic [ADDR_W-1:0] linkreg,
    output logic              stack_err
);
    fetch_state_e      state, state_n;
    logic [ADDR_W-1:0] pc, pc_n, link_val;
    logic              accept;

    always_comb begin
        state_n = state;
        imem_en = 1'b0;
        accept  = 1'b0;
        unique case (state)
            IDLE:    state_n = ISSUE;
            ISSUE: begin
                imem_en = 1'b1;
                state_n = CAPTURE;
            end
            CAPTURE: state_n = HOLD;
            HOLD: begin
                accept  = ins_ready;
                state_n = ins_ready ? ISSUE : HOLD;
            end
        endcase
    end

    assign pc_n      = load_pc ? new_pc : ret ? link_val : pc + ADDR_W'(1);
    assign imem_addr = pc;
    assign linkreg   = link_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            ins       <= '0;
            ins_addr  <= '0;
            ins_valid <= 1'b0;
        end else begin
            state <= state_n;
            if (state == CAPTURE) begin
                ins       <= imem_data;
                ins_addr  <= pc;
                ins_valid <= 1'b1;
            end
            if (accept) begin
                ins_valid <= 1'b0;
                pc        <= pc_n;
            end
        end
    end

`ifdef LINK_STACK_EN
    link_stack #(.W(ADDR_W), .DEPTH(LINK_DEPTH)) u_link_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept && load_linkreg),
        .pop   (accept && ret),
        .din   (new_linkreg),
        .top   (link_val),
        .err   (stack_err)
    );
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) link_val <= '0;
        else if (accept && load_linkreg) link_val <= new_linkreg;
    end

    assign stack_err = 1'b0;
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scoreboard bench for instruction_fetch (follows LINK_STACK_EN)
module tb_instruction_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] imem_addr;
    logic        imem_en;
    logic [20:0] imem_data = '0;
    logic [20:0] ins;
    logic [15:0] ins_addr;
    logic        ins_valid;
    logic        ins_ready = 1'b0;
    logic        load_pc = 1'b0;
    logic [15:0] new_pc = '0;
    logic        load_linkreg = 1'b0;
    logic [15:0] new_linkreg = '0;
    logic        ret = 1'b0;
    logic [15:0] linkreg;
    logic        stack_err;

    instruction_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_addr    (imem_addr),
        .imem_en      (imem_en),
        .imem_data    (imem_data),
        .ins          (ins),
        .ins_addr     (ins_addr),
        .ins_valid    (ins_valid),
        .ins_ready    (ins_ready),
        .load_pc      (load_pc),
        .new_pc       (new_pc),
        .load_linkreg (load_linkreg),
        .new_linkreg  (new_linkreg),
        .ret          (ret),
        .linkreg      (linkreg),
        .stack_err    (stack_err)
    );

    always #5 clk = ~clk;

    // memory[n] = n + 21'h100, synchronous read
    always @(posedge clk) if (imem_en) imem_data <= 21'(imem_addr) + 21'h100;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [15:0] a;
        logic [20:0] d;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic        prev = 1'b0;
    logic [15:0] m_cur = '0;

    function automatic exp_t mk(input logic [15:0] a);
        return {a, 21'(a) + 21'h100};
    endfunction

`ifdef LINK_STACK_EN
    logic [15:0] mstk[$];
    logic        m_err = 1'b0;
    function automatic logic [15:0] m_top();
        return mstk.size() != 0 ? mstk[0] : 16'h0;
    endfunction
    function automatic logic m_err_f();
        return m_err;
    endfunction
    task automatic m_link_upd(input logic ll, input logic [15:0] nl, input logic rt);
        if (rt && ll) begin
            if (mstk.size() == 0) begin
                m_err = 1'b1;
                mstk.push_front(nl);
            end else mstk[0] = nl;
        end else if (ll) begin
            mstk.push_front(nl);
            if (mstk.size() > 4) void'(mstk.pop_back());
        end else if (rt) begin
            if (mstk.size() == 0) m_err = 1'b1;
            else void'(mstk.pop_front());
        end
    endtask
    task automatic m_reset();
        mstk.delete();
        m_err = 1'b0;
        sb.delete();
        m_cur = '0;
    endtask
`else
    logic [15:0] m_link = '0;
    function automatic logic [15:0] m_top();
        return m_link;
    endfunction
    function automatic logic m_err_f();
        return 1'b0;
    endfunction
    task automatic m_link_upd(input logic ll, input logic [15:0] nl, input logic rt);
        if (ll) m_link = nl;
    endtask
    task automatic m_reset();
        m_link = '0;
        sb.delete();
        m_cur = '0;
    endtask
`endif

    // scoreboard consumer: each new valid instruction must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && ins_valid && !prev) begin
            e = sb.size() != 0 ? sb.pop_front() : '1;
            chk("ins_addr", ins_addr, e.a);
            chk("ins", ins, e.d);
        end
        prev <= rst_n && ins_valid;
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, ins_valid, 0);
        chk({tag, "_imem_en"}, imem_en, 0);
        chk({tag, "_ins"}, ins, 0);
        chk({tag, "_ins_addr"}, ins_addr, 0);
        chk({tag, "_imem_addr"}, imem_addr, 0);
        chk({tag, "_linkreg"}, linkreg, 0);
        chk({tag, "_stack_err"}, stack_err, 0);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!ins_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("valid_wait", ins_valid, 1);
    endtask

    task automatic accept(input logic lp, input logic [15:0] np, input logic ll,
                          input logic [15:0] nl, input logic rt, input logic lat_chk);
        int          n;
        logic [15:0] nxt;
        wait_valid(n);
        if (lat_chk) chk("latency", n, 2);
        nxt = lp ? np : rt ? m_top() : m_cur + 16'h1;
        m_link_upd(ll, nl, rt);
        sb.push_back(mk(nxt));
        m_cur = nxt;
        {load_pc, new_pc, load_linkreg, new_linkreg, ret} = {lp, np, ll, nl, rt};
        ins_ready = 1'b1;
        @(negedge clk);
        {load_pc, new_pc, load_linkreg, new_linkreg, ret} = '0;
        ins_ready = 1'b0;
        chk("issue_after_accept", imem_en, 1);
        chk("valid_after_accept", ins_valid, 0);
        chk("linkreg", linkreg, m_top());
        chk("stack_err", stack_err, m_err_f());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk_reset("rst");
        m_reset();
        sb.push_back(mk(16'h0000));
        rst_n = 1'b1;
        @(negedge clk);
        chk("boot_issue_en", imem_en, 1);
        chk("boot_issue_valid", ins_valid, 0);
        @(negedge clk);
        chk("boot_capture_en", imem_en, 0);
        chk("boot_capture_valid", ins_valid, 0);
        @(negedge clk);
        chk("boot_valid", ins_valid, 1);
        accept(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        accept(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
        wait_valid(n);
        chk("latency", n, 2);
        repeat (5) begin
            @(negedge clk);
            chk("hold_addr", ins_addr, m_cur);
            chk("hold_ins", ins, 21'(m_cur) + 21'h100);
            chk("hold_valid", ins_valid, 1);
            chk("hold_imem_en", imem_en, 0);
        end
        accept(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        accept(1'b1, 16'h0040, 1'b0, 16'h0, 1'b0, 1'b1);
        accept(1'b1, 16'hFFFF, 1'b0, 16'h0, 1'b0, 1'b1);
        accept(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
        accept(1'b1, 16'h0100, 1'b1, 16'h0006, 1'b0, 1'b1);
        accept(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
        accept(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1);
        accept(1'b0, 16'h0, 1'b1, 16'h0033, 1'b1, 1'b1);
        accept(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
        @(negedge clk);
        chk("pre_rst_capture_valid", ins_valid, 0);
        #2 rst_n = 1'b0;
        #1 chk_reset("rst_mid");
        m_reset();
        @(negedge clk);
        sb.push_back(mk(16'h0000));
        rst_n = 1'b1;
        accept(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        accept(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
`ifdef LINK_STACK_EN
        for (int i = 1; i <= 5; i++) accept(1'b1, 16'h0200 + 16'(i), 1'b1, 16'(i), 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) accept(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1);
        chk("stack_err_final", stack_err, 1);
`endif
        wait_valid(n);
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage feeding the instruction decoder. Owns the program counter and link register, reads 21-bit instruction words from a synchronous-read instruction memory, and presents each word with its address under a valid/ready handshake. Applies the decoder's redirect commands (jump, call with link, return) on the cycle an instruction is accepted.

## Interface
- `ADDR_W`, 16, PC / instruction address width
- `INS_W`, 21, instruction word width
- `RESET_PC`, 16'h0000, PC value after reset

- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `imem_addr`  out  ADDR_W  instruction memory address; always equals PC
- `imem_en`  out  1  memory read enable; data is returned the following cycle
- `imem_data`  in  INS_W  memory read data, valid one cycle after `imem_en`
- `ins`  out  INS_W  fetched instruction to the decoder
- `ins_addr`  out  ADDR_W  address of `ins`
- `ins_valid`  out  1  `ins`/`ins_addr` hold a valid instruction
- `ins_ready`  in  1  decoder accepts the instruction this cycle
- `load_pc`  in  1  redirect: next PC = `new_pc`
- `new_pc`  in  ADDR_W  jump/call target
- `load_linkreg`  in  1  store `new_linkreg` (call)
- `new_linkreg`  in  ADDR_W  return address (instruction address + 1)
- `ret`  in  1  next PC = current link value
- `linkreg`  out  ADDR_W  current link value (top of stack when the stack is compiled in)
- `stack_err`  out  1  sticky link-stack underflow; constant 0 without `LINK_STACK_EN`

## Operation
- FSM states and transitions:
  - IDLE goes to ISSUE.
  - ISSUE: `imem_en`=1, then goes to CAPTURE.
  - CAPTURE: `ins`<=`imem_data`, `ins_addr`<=PC, `ins_valid`<=1, then goes to HOLD.
  - HOLD: waits for `ins_ready`=1. On acceptance: `ins_valid`<=0, PC updated, then goes to ISSUE.
- `load_pc`, `load_linkreg` and `ret` are sampled only in the HOLD acceptance cycle and ignored otherwise.
- Next-PC priority: `load_pc` (`new_pc`), then `ret` (link value), then PC+1.
- PC+1 is computed modulo 2^ADDR_W, so 16'hFFFF wraps to 16'h0000.
- `load_linkreg` updates the link register on acceptance. It is independent of `load_pc`.
- `ret` and `load_linkreg` in the same acceptance cycle: PC <= old link value, link <= `new_linkreg`.
- `imem_en`=0 in every state except ISSUE.
- Reset values: PC=`RESET_PC`, `ins`=0, `ins_addr`=0, `ins_valid`=0, `imem_en`=0, `linkreg`=0, `stack_err`=0, stack empty, state IDLE.
- Reset asserted mid-operation clears all state immediately. Any in-flight memory read is discarded.

## Timing
- Reset released before edge 0: ISSUE at edge 1, CAPTURE at edge 2, so `ins_valid`=1 after edge 2.
- Throughput: one instruction per 3 cycles when `ins_ready` is held at 1.
- Fetch latency from acceptance to the next `ins_valid` is 2 cycles.
- While `ins_ready`=0: `ins`, `ins_addr` and `ins_valid` are held stable and no reads are issued.
- `linkreg` and `stack_err` are registered and update on the edge after acceptance.

## Configuration
- `LINK_STACK_EN` defined: the link register becomes a 4-entry LIFO.
  - `load_linkreg` pushes. When full, the oldest entry is dropped.
  - `ret` pops, and PC takes the popped value.
  - Simultaneous `ret` and `load_linkreg` replace the top entry.
  - Pop when empty returns 0 and sets `stack_err` until reset.
  - `linkreg` shows the top entry, or 0 when empty.
- `LINK_STACK_EN` undefined: single link register. `ret` reads it without modifying it; `stack_err` is tied to 0.

## Structure
- Shared package `proc_pkg` holds:
  - `INS_W`, `ADDR_W`, `LINK_DEPTH`=4
  - fetch FSM state typedef: IDLE, ISSUE, CAPTURE, HOLD
- One sub-module, `link_stack`: push/pop/replace, top output, underflow flag.
  - Instantiated only under `LINK_STACK_EN`.
  - Otherwise a plain register is used in its place.

## Test plan
- Reset release, memory[n]=n+21'h100, `ins_ready`=1 → `ins_addr` sequence 0,1,2 at 3-cycle spacing with `ins`=21'h100,21'h101,21'h102; first `ins_valid` after edge 2.
- Hold `ins_ready`=0 for 5 cycles in HOLD → `ins`/`ins_addr` unchanged, `imem_en`=0 throughout; accept → next read issued on the following cycle.
- Accept with `load_pc`=1, `new_pc`=16'h0040 → next `ins_addr`=16'h0040; PC 16'hFFFF accepted without redirect → next `ins_addr`=16'h0000.
- Call: accept with `load_pc`=1, `new_pc`=16'h0100, `load_linkreg`=1, `new_linkreg`=16'h0006 → `linkreg`=16'h0006, next `ins_addr`=16'h0100; later accept with `ret`=1 → next `ins_addr`=16'h0006.
- With `LINK_STACK_EN`: push 1,2,3,4,5 then 5 rets → PCs 5,4,3,2 then 0, with `stack_err`=1 after the fifth.
- Assert `rst_n`=0 during CAPTURE → all outputs go to reset values at once; after release, fetch restarts at `RESET_PC`.
